// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register-file writeback front end.
package regwb_pkg;

  localparam int unsigned REG_COUNT = 16;
  localparam logic [3:0]  PC_REG    = 4'd15;

  // One queued writeback result.
  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // Which source wins the single enqueue slot this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_ALU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_if.sv
// Handshake and register-file bus for reg_writeback.
// master = result sources / issue / register file side, slave = reg_writeback.
interface reg_writeback_if;

  logic                                 pulse_en;
  logic                                 alu_valid;
  logic                                 alu_ready;
  logic [3:0]                           alu_rd;
  logic [31:0]                          alu_data;
  logic                                 ld_valid;
  logic                                 ld_ready;
  logic [3:0]                           ld_rd;
  logic [31:0]                          ld_data;
  logic                                 claim_valid;
  logic [3:0]                           claim_rd;
  logic                                 write;
  logic [3:0]                           rdest;
  logic [31:0]                          write_data;
  logic                                 pc_load;
  logic [31:0]                          pc_value;
  logic [regwb_pkg::REG_COUNT-1:0]      busy;

  modport master (
    output pulse_en, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           claim_valid, claim_rd,
    input  alu_ready, ld_ready, write, rdest, write_data, pc_load, pc_value, busy
  );

  modport slave (
    input  pulse_en, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           claim_valid, claim_rd,
    output alu_ready, ld_ready, write, rdest, write_data, pc_load, pc_value, busy
  );

endinterface

// File: rtl/reg_writeback_fifo.sv
// In-order FIFO of writeback entries. Pointers carry one extra wrap bit so
// full and empty are told apart by the MSB alone.
module wb_fifo
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback front end: arbitrates ALU/load results into an in-order FIFO,
// drains one entry per pulse_en cycle to the register file, turns writes to
// the PC slot into a registered pc_load pulse, and tracks per-register busy.
module reg_writeback #(
  parameter int unsigned DEPTH  = 4,
  parameter logic [3:0]  PC_REG = regwb_pkg::PC_REG
) (
  input  logic            clk,
  input  logic            rst,
  reg_writeback_if.slave  bus
);

  import regwb_pkg::*;

  wb_src_e                src;
  wb_entry_t              push_entry;
  wb_entry_t              head;
  logic                   full, empty, push, pop, head_is_pc;
  logic [REG_COUNT-1:0]   busy_q, busy_d;
  logic                   pc_load_q, pc_load_d;
  logic [31:0]            pc_value_q, pc_value_d;

  // Enqueue arbitration: load is older, so it wins the single push slot.
  always_comb begin
    src        = SRC_NONE;
    push_entry = '0;
    if (!full) begin
      if (bus.ld_valid) begin
        src        = SRC_LD;
        push_entry = '{rd: bus.ld_rd, data: bus.ld_data};
      end else if (bus.alu_valid) begin
        src        = SRC_ALU;
        push_entry = '{rd: bus.alu_rd, data: bus.alu_data};
      end
    end
  end

  // Readiness looks at full only; a same-cycle pop never frees a slot.
  assign bus.ld_ready  = !full;
  assign bus.alu_ready = !full && !bus.ld_valid;
  assign push          = (src != SRC_NONE);
  assign pop           = bus.pulse_en && !empty;
  assign head_is_pc    = (head.rd == PC_REG);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_entry),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Head presentation to the register file; zeroed while empty.
  always_comb begin
    bus.write      = 1'b0;
    bus.rdest      = '0;
    bus.write_data = '0;
    if (!empty) begin
      bus.write      = !head_is_pc;
      bus.rdest      = head.rd;
      bus.write_data = head.data;
    end
  end

  // Scoreboard and PC redirect next state; a claim is applied after the
  // clear so a same-register claim survives the retiring write.
  always_comb begin
    busy_d     = busy_q;
    pc_load_d  = pop && head_is_pc;
    pc_value_d = pc_value_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (bus.claim_valid) busy_d[bus.claim_rd] = 1'b1;
    if (pc_load_d) pc_value_d = head.data;
  end

  // Scoreboard and PC pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      pc_load_q  <= 1'b0;
      pc_value_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pc_load_q  <= pc_load_d;
      pc_value_q <= pc_value_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.pc_load  = pc_load_q;
  assign bus.pc_value = pc_value_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus a randomized run, all
// compared against a queue-based reference model of the writeback queue.
module tb_reg_writeback;
  import regwb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [3:0]  PC    = 4'd15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_writeback_if ifc ();

  reg_writeback #(.DEPTH(DEPTH), .PC_REG(PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  wb_entry_t   q[$];
  logic [15:0] m_busy;
  bit          m_pc_load;
  logic [31:0] m_pc_value;
  bit          m_ld_acc, m_alu_acc;
  wb_entry_t   model_log[$];
  wb_entry_t   dut_log[$];

  function automatic void m_reset();
    q.delete();
    m_busy     = '0;
    m_pc_load  = 0;
    m_pc_value = '0;
    m_ld_acc   = 0;
    m_alu_acc  = 0;
  endfunction

  // Model of one clock edge, from the inputs applied during that cycle.
  function automatic void model_edge();
    bit        room, do_pop;
    wb_entry_t h;
    if (rst) begin
      m_reset();
      return;
    end
    room      = q.size() < DEPTH;
    do_pop    = ifc.pulse_en && q.size() > 0;
    m_ld_acc  = room && ifc.ld_valid;
    m_alu_acc = room && !ifc.ld_valid && ifc.alu_valid;
    m_pc_load = 0;
    if (do_pop) begin
      h = q.pop_front();
      m_busy[h.rd] = 1'b0;
      if (h.rd == PC) begin
        m_pc_load  = 1;
        m_pc_value = h.data;
      end else begin
        model_log.push_back(h);
      end
    end
    if (ifc.claim_valid) m_busy[ifc.claim_rd] = 1'b1;
    if (m_ld_acc)       q.push_back('{rd: ifc.ld_rd,  data: ifc.ld_data});
    else if (m_alu_acc) q.push_back('{rd: ifc.alu_rd, data: ifc.alu_data});
  endfunction

  // Record what the register file would see, advance one edge.
  task automatic tick();
    if (!rst && ifc.write && ifc.pulse_en)
      dut_log.push_back('{rd: ifc.rdest, data: ifc.write_data});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    ifc.pulse_en = 0; ifc.alu_valid = 0; ifc.alu_rd = '0; ifc.alu_data = '0;
    ifc.ld_valid = 0; ifc.ld_rd = '0; ifc.ld_data = '0;
    ifc.claim_valid = 0; ifc.claim_rd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #3 rst = 0;
    m_reset();
    #1;
    n_checks++; if (ifc.write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %0b want 0", ifc.write); end
    n_checks++; if (ifc.rdest !== 4'd0) begin n_fail++; $display("FAIL reset_rdest got %0d want 0", ifc.rdest); end
    n_checks++; if (ifc.write_data !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", ifc.write_data); end
    n_checks++; if (ifc.busy !== 16'd0) begin n_fail++; $display("FAIL reset_busy got %h want 0", ifc.busy); end
    n_checks++; if (ifc.pc_load !== 1'b0 || ifc.pc_value !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %0b/%h want 0/0", ifc.pc_load, ifc.pc_value); end
    n_checks++; if (ifc.ld_ready !== 1'b1 || ifc.alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b%0b want 11", ifc.ld_ready, ifc.alu_ready); end
  endtask

  task automatic test_alu_basic();
    dut_log.delete(); model_log.delete();
    ifc.pulse_en = 1; ifc.alu_valid = 1; ifc.alu_rd = 4'd3; ifc.alu_data = 32'hDEADBEEF;
    tick();
    ifc.alu_valid = 0;
    #1;
    n_checks++; if (ifc.write !== 1'b1) begin n_fail++; $display("FAIL alu_write got %0b want 1", ifc.write); end
    n_checks++; if (ifc.rdest !== 4'd3) begin n_fail++; $display("FAIL alu_rdest got %0d want 3", ifc.rdest); end
    n_checks++; if (ifc.write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wdata got %h want deadbeef", ifc.write_data); end
    tick();
    n_checks++; if (ifc.write !== 1'b0 || ifc.rdest !== 4'd0) begin n_fail++; $display("FAIL alu_drained got write=%0b rdest=%0d want 0/0", ifc.write, ifc.rdest); end
    n_checks++; if (dut_log.size() != 1 || dut_log[0] !== {4'd3, 32'hDEADBEEF}) begin n_fail++; $display("FAIL alu_commit got %0d commits want 1 of rd3", dut_log.size()); end
  endtask

  task automatic test_priority();
    dut_log.delete(); model_log.delete();
    ifc.pulse_en = 1;
    ifc.ld_valid = 1;  ifc.ld_rd = 4'd1;  ifc.ld_data = 32'h11;
    ifc.alu_valid = 1; ifc.alu_rd = 4'd2; ifc.alu_data = 32'h22;
    #1;
    n_checks++; if (ifc.alu_ready !== 1'b0 || ifc.ld_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready got ld=%0b alu=%0b want 1/0", ifc.ld_ready, ifc.alu_ready); end
    tick();
    ifc.ld_valid = 0;
    #1;
    n_checks++; if (ifc.alu_ready !== 1'b1) begin n_fail++; $display("FAIL prio_alu_ready got %0b want 1", ifc.alu_ready); end
    tick();
    ifc.alu_valid = 0;
    repeat (2) tick();
    n_checks++;
    if (dut_log.size() != 2 || dut_log[0] !== {4'd1, 32'h11} || dut_log[1] !== {4'd2, 32'h22}) begin
      n_fail++; $display("FAIL prio_order got %0d commits (first rd%0d) want rd1 then rd2", dut_log.size(), dut_log.size() > 0 ? dut_log[0].rd : 4'd0);
    end
  endtask

  task automatic test_full();
    dut_log.delete(); model_log.delete();
    ifc.pulse_en = 0;
    for (int i = 0; i < 4; i++) begin
      ifc.alu_valid = 1; ifc.alu_rd = 4'(8 + i); ifc.alu_data = $urandom;
      tick();
    end
    #1;
    n_checks++; if (ifc.alu_ready !== 1'b0 || ifc.ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got ld=%0b alu=%0b want 0/0", ifc.ld_ready, ifc.alu_ready); end
    ifc.alu_rd = 4'd12; ifc.alu_data = 32'hBAD0BAD0;
    tick();
    ifc.alu_valid = 0; ifc.pulse_en = 1;
    tick();
    n_checks++; if (ifc.alu_ready !== 1'b1 || ifc.ld_ready !== 1'b1) begin n_fail++; $display("FAIL full_release got ld=%0b alu=%0b want 1/1", ifc.ld_ready, ifc.alu_ready); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      n_checks++; if (dut_log.size() != k) begin n_fail++; $display("FAIL full_drain_rate got %0d commits want %0d", dut_log.size(), k); end
    end
    n_checks++;
    if (dut_log != model_log || dut_log.size() != 4 || dut_log[0].rd !== 4'd8 || dut_log[3].rd !== 4'd11) begin
      n_fail++; $display("FAIL full_order got %0d commits want rd8..rd11 matching model", dut_log.size());
    end
  endtask

  task automatic test_pc_redirect();
    dut_log.delete(); model_log.delete();
    ifc.pulse_en = 0; ifc.alu_valid = 1; ifc.alu_rd = PC; ifc.alu_data = 32'h100;
    tick();
    ifc.alu_valid = 0;
    #1;
    n_checks++; if (ifc.write !== 1'b0 || ifc.rdest !== PC || ifc.pc_load !== 1'b0) begin n_fail++; $display("FAIL pc_head got write=%0b rdest=%0d pc_load=%0b want 0/15/0", ifc.write, ifc.rdest, ifc.pc_load); end
    ifc.pulse_en = 1;
    tick();
    n_checks++; if (ifc.pc_load !== 1'b1 || ifc.pc_value !== 32'h100) begin n_fail++; $display("FAIL pc_pulse got %0b/%h want 1/00000100", ifc.pc_load, ifc.pc_value); end
    tick();
    n_checks++; if (ifc.pc_load !== 1'b0) begin n_fail++; $display("FAIL pc_one_cycle got %0b want 0", ifc.pc_load); end
    n_checks++; if (dut_log.size() != 0) begin n_fail++; $display("FAIL pc_no_write got %0d commits want 0", dut_log.size()); end
  endtask

  task automatic test_scoreboard();
    ifc.pulse_en = 0; ifc.claim_valid = 1; ifc.claim_rd = 4'd5;
    tick();
    ifc.claim_valid = 0;
    #1;
    n_checks++; if (ifc.busy[5] !== 1'b1) begin n_fail++; $display("FAIL sb_claim got %0b want 1", ifc.busy[5]); end
    ifc.alu_valid = 1; ifc.alu_rd = 4'd5; ifc.alu_data = 32'h55;
    tick();
    ifc.alu_valid = 0; ifc.pulse_en = 1; ifc.claim_valid = 1; ifc.claim_rd = 4'd5;
    tick();
    ifc.claim_valid = 0;
    #1;
    n_checks++; if (ifc.busy[5] !== 1'b1) begin n_fail++; $display("FAIL sb_claim_wins got %0b want 1", ifc.busy[5]); end
    tick();
    n_checks++; if (ifc.busy !== 16'h0020 || ifc.pc_load !== 1'b0) begin n_fail++; $display("FAIL sb_empty_pulse got busy=%h pc_load=%0b want 0020/0", ifc.busy, ifc.pc_load); end
    ifc.pulse_en = 0; ifc.alu_valid = 1;
    tick();
    ifc.alu_valid = 0; ifc.pulse_en = 1; ifc.claim_valid = 1; ifc.claim_rd = 4'd6;
    tick();
    ifc.claim_valid = 0;
    #1;
    n_checks++; if (ifc.busy[5] !== 1'b0 || ifc.busy[6] !== 1'b1) begin n_fail++; $display("FAIL sb_clear got b5=%0b b6=%0b want 0/1", ifc.busy[5], ifc.busy[6]); end
  endtask

  task automatic test_async_reset();
    dut_log.delete(); model_log.delete();
    ifc.pulse_en = 0;
    for (int i = 0; i < 4; i++) begin
      ifc.claim_valid = 1; ifc.claim_rd = 4'(4 + i);
      ifc.alu_valid = (i < 3); ifc.alu_rd = 4'(1 + i); ifc.alu_data = 32'hA0 + 32'(i);
      tick();
    end
    ifc.claim_valid = 0; ifc.alu_valid = 0;
    #1;
    n_checks++; if (ifc.busy !== 16'h00F0 || q.size() != 3) begin n_fail++; $display("FAIL arst_setup got busy=%h want 00f0", ifc.busy); end
    #1 rst = 1;
    #1;
    n_checks++; if (ifc.write !== 1'b0 || ifc.rdest !== 4'd0 || ifc.write_data !== 32'd0) begin n_fail++; $display("FAIL arst_outputs got %0b/%0d/%h want 0/0/0", ifc.write, ifc.rdest, ifc.write_data); end
    n_checks++; if (ifc.busy !== 16'd0 || ifc.ld_ready !== 1'b1 || ifc.alu_ready !== 1'b1) begin n_fail++; $display("FAIL arst_state got busy=%h ready=%0b%0b want 0000/11", ifc.busy, ifc.ld_ready, ifc.alu_ready); end
    m_reset();
    tick();
    #1 rst = 0;
    ifc.pulse_en = 1;
    repeat (3) tick();
    n_checks++; if (dut_log.size() != 0 || ifc.write !== 1'b0) begin n_fail++; $display("FAIL arst_no_commit got %0d commits want 0", dut_log.size()); end
  endtask

  task automatic test_random();
    bit        ne;
    wb_entry_t h;
    dut_log.delete(); model_log.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ifc.ld_valid || m_ld_acc) begin
        ifc.ld_valid = ($urandom_range(0, 2) == 0);
        ifc.ld_rd    = 4'($urandom_range(0, 15));
        ifc.ld_data  = $urandom;
      end
      if (!ifc.alu_valid || m_alu_acc) begin
        ifc.alu_valid = ($urandom_range(0, 1) == 0);
        ifc.alu_rd    = 4'($urandom_range(0, 15));
        ifc.alu_data  = $urandom;
      end
      ifc.pulse_en    = ($urandom_range(0, 2) != 0);
      ifc.claim_valid = ($urandom_range(0, 3) == 0);
      ifc.claim_rd    = 4'($urandom_range(0, 15));
      #1;
      ne = q.size() != 0;
      h  = ne ? q[0] : '0;
      n_checks++; if (ifc.write !== (ne && h.rd != PC)) begin n_fail++; $display("FAIL rnd_write cyc %0d got %0b want %0b", cyc, ifc.write, ne && h.rd != PC); end
      n_checks++; if (ifc.rdest !== h.rd || ifc.write_data !== h.data) begin n_fail++; $display("FAIL rnd_head cyc %0d got %0d/%h want %0d/%h", cyc, ifc.rdest, ifc.write_data, h.rd, h.data); end
      n_checks++; if (ifc.ld_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ld_ready cyc %0d got %0b", cyc, ifc.ld_ready); end
      n_checks++; if (ifc.alu_ready !== (q.size() < DEPTH && !ifc.ld_valid)) begin n_fail++; $display("FAIL rnd_alu_ready cyc %0d got %0b", cyc, ifc.alu_ready); end
      n_checks++; if (ifc.busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %h want %h", cyc, ifc.busy, m_busy); end
      n_checks++; if (ifc.pc_load !== m_pc_load || (m_pc_load && ifc.pc_value !== m_pc_value)) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %0b/%h want %0b/%h", cyc, ifc.pc_load, ifc.pc_value, m_pc_load, m_pc_value); end
      tick();
    end
    n_checks++; if (dut_log != model_log) begin n_fail++; $display("FAIL rnd_commit_log got %0d commits want %0d", dut_log.size(), model_log.size()); end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_priority();
    test_full();
    test_pc_redirect();
    test_scoreboard();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
